// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Responder FSM states and funct3 size/sign codes shared with the
//             CPU load/store path.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Combinational byte-lane steering: byte enables, store
//             replication, load shift/extend and misalignment detection.
//  Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_addr_lo,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [31:0]           i_rword,
    output logic [3:0]            o_byte_en,
    output logic [31:0]           o_wword,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_err
);

    logic [31:0] w_rshift;

    assign w_rshift = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_byte_en = '0;
        o_wword   = '0;
        o_rdata   = '0;
        o_err     = 1'b0;
        case (i_funct3)
            c_F3_B, c_F3_BU: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wword   = {4{i_wdata[7:0]}};
                if (i_funct3 == c_F3_B)
                    o_rdata = DATA_WIDTH'($signed(w_rshift[7:0]));
                else
                    o_rdata = DATA_WIDTH'(w_rshift[7:0]);
            end
            c_F3_H, c_F3_HU: begin
                o_err     = i_addr_lo[0];
                o_byte_en = 4'b0011 << i_addr_lo;
                o_wword   = {2{i_wdata[15:0]}};
                if (i_funct3 == c_F3_H)
                    o_rdata = DATA_WIDTH'($signed(w_rshift[15:0]));
                else
                    o_rdata = DATA_WIDTH'(w_rshift[15:0]);
            end
            c_F3_W: begin
                o_err     = |i_addr_lo;
                o_byte_en = 4'b1111;
                o_wword   = i_wdata[31:0];
                o_rdata   = DATA_WIDTH'($signed(w_rshift));
            end
            default: o_err = 1'b1;
        endcase
        // An erroring access must neither write nor return data.
        if (o_err) begin
            o_byte_en = '0;
            o_rdata   = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Fixed-latency byte-addressed memory responder with valid/ready
//             request and response channels.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int LATENCY       = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     ReqWrite,
    input  logic [ADDRESS_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0]    ReqWData,
    input  logic [2:0]               ReqFunct3,
    output logic                     RespValid,
    input  logic                     RespReady,
    output logic [DATA_WIDTH-1:0]    RespRData,
    output logic                     RespErr
);

    localparam int         c_DEPTH  = 2 ** (ADDRESS_WIDTH - 2);
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_write;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [2:0]               r_funct3;

    // Storage is never reset; its contents survive RST.
    logic [31:0]              r_mem [c_DEPTH];

    logic [31:0]              w_rword;
    logic [3:0]               w_byte_en;
    logic [31:0]              w_wword;
    logic [DATA_WIDTH-1:0]    w_rdata;
    logic                     w_err;
    logic                     w_commit;

    assign w_rword  = r_mem[r_addr[ADDRESS_WIDTH-1:2]];
    assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0) && r_write;

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_addr_lo  (r_addr[1:0]),
        .i_funct3   (r_funct3),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_byte_en  (w_byte_en),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_err      (w_err)
    );

    always_ff @(posedge CLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i])
                    r_mem[r_addr[ADDRESS_WIDTH-1:2]][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= 3'd0;
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
            RespRData <= '0;
            RespErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_write  <= ReqWrite;
                        r_addr   <= ReqAddr;
                        r_wdata  <= ReqWData;
                        r_funct3 <= ReqFunct3;
                        r_cnt    <= c_LAT_M1;
                        r_state  <= WAIT;
                        ReqReady <= 1'b0;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= RESP;
                        RespValid <= 1'b1;
                        RespErr   <= w_err;
                        RespRData <= r_write ? '0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here leaves one cycle before the next accept.
                    if (RespReady) begin
                        r_state   <= IDLE;
                        RespValid <= 1'b0;
                        ReqReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    RespValid <= 1'b0;
                    ReqReady  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench: directed and random loads/stores against a
//             byte-array reference model, plus LATENCY=1/15 throughput builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_LAT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [8:0]  ReqAddr;
    logic [31:0] ReqWData;
    logic [2:0]  ReqFunct3;
    logic        RespValid, RespReady, RespErr;
    logic [31:0] RespRData;

    logic        rst_tp;
    logic        tp_one = 1'b1;
    logic        tp_zero = 1'b0;
    logic [8:0]  tp_addr = 9'h000;
    logic [31:0] tp_wdata = 32'h0;
    logic [2:0]  tp_f3 = 3'b010;
    logic        l1_req_ready, l1_resp_valid, l1_err;
    logic [31:0] l1_rdata;
    logic        l15_req_ready, l15_resp_valid, l15_err;
    logic [31:0] l15_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [0:511];
    logic [31:0] init_words [0:16];

    always #5 CLK = ~CLK;

    mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .LATENCY(c_LAT)) dut (
        .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .ReqFunct3(ReqFunct3), .RespValid(RespValid), .RespReady(RespReady),
        .RespRData(RespRData), .RespErr(RespErr)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .LATENCY(1)) dut_l1 (
        .CLK(CLK), .RST(rst_tp), .ReqValid(tp_one), .ReqReady(l1_req_ready),
        .ReqWrite(tp_zero), .ReqAddr(tp_addr), .ReqWData(tp_wdata),
        .ReqFunct3(tp_f3), .RespValid(l1_resp_valid), .RespReady(tp_one),
        .RespRData(l1_rdata), .RespErr(l1_err)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .LATENCY(15)) dut_l15 (
        .CLK(CLK), .RST(rst_tp), .ReqValid(tp_one), .ReqReady(l15_req_ready),
        .ReqWrite(tp_zero), .ReqAddr(tp_addr), .ReqWData(tp_wdata),
        .ReqFunct3(tp_f3), .RespValid(l15_resp_valid), .RespReady(tp_one),
        .RespRData(l15_rdata), .RespErr(l15_err)
    );

    // Cycle stamps of RespValid rising edges for the throughput builds.
    int   cyc = 0;
    logic l1_prev = 1'b0;
    logic l15_prev = 1'b0;
    int   q1[$];
    int   q15[$];

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        l1_prev  <= l1_resp_valid;
        l15_prev <= l15_resp_valid;
        if (l1_resp_valid && !l1_prev && q1.size() < 6) q1.push_back(cyc);
        if (l15_resp_valid && !l15_prev && q15.size() < 6) q15.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-granular memory, access size from funct3, applies stores.
    task automatic model(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] exp_d, output logic exp_e);
        int    size;
        bit    sgn;
        int    a;
        size = 0;
        sgn  = 1'b0;
        a    = int'(addr);
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        exp_e = (size == 0) || (a % size != 0);
        exp_d = 32'h0;
        if (!exp_e && wr) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else if (!exp_e) begin
            for (int i = 0; i < size; i++) exp_d = exp_d | (32'(ref_mem[a + i]) << (8 * i));
            if (sgn && size < 4 && exp_d[8*size-1]) exp_d = exp_d | (32'hFFFF_FFFF << (8 * size));
        end
    endtask

    task automatic xact(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        model(wr, addr, wd, f3, exp_d, exp_e);
        @(negedge CLK);
        n = 0;
        while (ReqReady !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        check("req_ready_idle", 32'(ReqReady), 32'd1);
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqAddr   = addr;
        ReqWData  = wd;
        ReqFunct3 = f3;
        @(posedge CLK); #1;
        // Junk on the request bus while busy must have no effect.
        ReqWrite  = 1'($urandom);
        ReqAddr   = 9'($urandom);
        ReqWData  = $urandom;
        ReqFunct3 = 3'($urandom);
        check("req_ready_busy", 32'(ReqReady), 32'd0);
        n = 0;
        while (RespValid !== 1'b1 && n < 40) begin @(posedge CLK); #1; n++; end
        check("latency", 32'(n), 32'(c_LAT));
        check("resp_rdata", RespRData, exp_d);
        check("resp_err", 32'(RespErr), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'($urandom);
            ReqAddr  = 9'($urandom);
            @(posedge CLK); #1;
            check("hold_valid", 32'(RespValid), 32'd1);
            check("hold_rdata", RespRData, exp_d);
            check("hold_req_ready", 32'(ReqReady), 32'd0);
        end
        rd        = RespRData;
        er        = RespErr;
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(posedge CLK); #1;
        check("resp_drop", 32'(RespValid), 32'd0);
        check("idle_ready", 32'(ReqReady), 32'd1);
        RespReady = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [8:0]  a;
        RST       = 1'b1;
        rst_tp    = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqAddr   = '0;
        ReqWData  = '0;
        ReqFunct3 = 3'b010;
        RespReady = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        #12;
        check("rst_req_ready", 32'(ReqReady), 32'd1);
        check("rst_resp_valid", 32'(RespValid), 32'd0);
        check("rst_rdata", RespRData, 32'd0);
        check("rst_err", 32'(RespErr), 32'd0);
        @(negedge CLK);
        RST    = 1'b0;
        rst_tp = 1'b0;

        // Fill the working region and the top word with known data.
        for (int i = 0; i < 17; i++) begin
            init_words[i] = $urandom;
            a = (i == 16) ? 9'h1FC : 9'(i * 4);
            xact(1'b1, a, init_words[i], 3'b010, 0, rd, er);
        end

        xact(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, rd, er);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        check("lw_deadbeef_err", 32'(er), 32'd0);

        xact(1'b1, 9'h010, 32'h0, 3'b010, 0, rd, er);
        xact(1'b1, 9'h013, 32'h0000_0080, 3'b000, 0, rd, er);
        xact(1'b0, 9'h013, 32'h0, 3'b000, 0, rd, er);
        check("lb_sext", rd, 32'hFFFFFF80);
        xact(1'b0, 9'h013, 32'h0, 3'b100, 0, rd, er);
        check("lbu_zext", rd, 32'h00000080);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er);
        check("lw_after_sb", rd, 32'h80000000);

        xact(1'b0, 9'h011, 32'h0, 3'b001, 0, rd, er);
        check("lh_misalign_err", 32'(er), 32'd1);
        check("lh_misalign_data", rd, 32'd0);
        xact(1'b1, 9'h012, 32'h12345678, 3'b010, 0, rd, er);
        check("sw_misalign_err", 32'(er), 32'd1);
        xact(1'b0, 9'h010, 32'h0, 3'b010, 0, rd, er);
        check("sw_misalign_nowrite", rd, 32'h80000000);

        xact(1'b0, 9'h010, 32'h0, 3'b010, 5, rd, er);
        xact(1'b0, 9'h1FC, 32'h0, 3'b010, 0, rd, er);
        check("top_word", rd, init_words[16]);

        // Reset in the middle of a store: nothing may be committed.
        @(negedge CLK);
        ReqValid  = 1'b1;
        ReqWrite  = 1'b1;
        ReqAddr   = 9'h020;
        ReqWData  = 32'h11223344;
        ReqFunct3 = 3'b010;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        check("abort_req_ready", 32'(ReqReady), 32'd1);
        check("abort_resp_valid", 32'(RespValid), 32'd0);
        check("abort_rdata", RespRData, 32'd0);
        check("abort_err", 32'(RespErr), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        xact(1'b0, 9'h020, 32'h0, 3'b010, 0, rd, er);
        check("abort_mem_kept", rd, init_words[8]);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) a = 9'h1FC + 9'($urandom_range(0, 3));
            else a = 9'($urandom_range(0, 63));
            xact(1'($urandom), a, $urandom, 3'($urandom), $urandom_range(0, 3), rd, er);
        end

        check("tp_l1_count", 32'(q1.size() >= 4), 32'd1);
        for (int i = 1; i < q1.size(); i++) check("tp_l1_period", 32'(q1[i] - q1[i-1]), 32'd3);
        check("tp_l15_count", 32'(q15.size() >= 4), 32'd1);
        for (int i = 1; i < q15.size(); i++) check("tp_l15_period", 32'(q15[i] - q15[i-1]), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 9, byte-address width; storage is 2^ADDRESS_WIDTH bytes.
REQ-003 SHALL have parameter LATENCY, default 2, number of WAIT cycles per access; legal range 1..15.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ReqValid  input  1  initiator presents a request.
REQ-007 SHALL have port ReqReady  output  1  responder can accept a request.
REQ-008 SHALL have port ReqWrite  input  1  1 = store, 0 = load.
REQ-009 SHALL have port ReqAddr  input  ADDRESS_WIDTH  byte address.
REQ-010 SHALL have port ReqWData  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port ReqFunct3  input  3  access size and sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-012 SHALL have port RespValid  output  1  response available.
REQ-013 SHALL have port RespReady  input  1  initiator accepts the response.
REQ-014 SHALL have port RespRData  output  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 for stores and errors.
REQ-015 SHALL have port RespErr  output  1  access misaligned or ReqFunct3 illegal.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 ReqReady SHALL be 1 only in IDLE; RespValid SHALL be 1 only in RESP.
REQ-018 A request is accepted on an edge with ReqValid=1 and ReqReady=1; ReqWrite, ReqAddr, ReqWData and ReqFunct3 SHALL be latched on that edge, and the FSM SHALL move to WAIT.
REQ-019 A 4-bit wait counter SHALL load LATENCY-1 on acceptance, decrement in WAIT, and move the FSM to RESP on the edge where it is 0; RespValid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-020 Store commit SHALL occur on the WAIT->RESP edge, writing only the addressed lanes in little-endian order: sb 1 byte, sh 2 bytes, sw 4 bytes.
REQ-021 Load data SHALL be captured on the WAIT->RESP edge and held stable in RespRData throughout RESP. lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend.
REQ-022 Misalignment (halfword with Addr[0]=1, word with Addr[1:0]!=0) or illegal ReqFunct3 SHALL set RespErr=1 and RespRData=0, and SHALL suppress any store.
REQ-023 In RESP, the FSM SHALL hold until RespReady=1, then go to IDLE on that edge. No new request SHALL be accepted on that same edge (one idle cycle between transactions).
REQ-024 Request inputs SHALL be ignored outside IDLE; changing them mid-transaction SHALL NOT affect the result.
REQ-025 A word access at address 2^ADDRESS_WIDTH-4 SHALL be legal; addresses SHALL NOT wrap within an access.
REQ-026 A load following a store to the same address SHALL return the stored data.

Reset
REQ-027 RST=1 SHALL asynchronously force state IDLE, counter 0, ReqReady=1, RespValid=0, RespRData=0, RespErr=0.
REQ-028 Reset during WAIT SHALL abort the transaction; an uncommitted store SHALL NOT modify memory.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the funct3 size/sign constants, shared with the CPU load/store path.
REQ-031 Sub-module mem_lane_align SHALL be combinational and SHALL perform lane byte-enable generation, store shift, load shift/extend and misalignment detection.

Verification
REQ-032 sw 0xDEADBEEF @0x010, then lw @0x010 -> RespRData=0xDEADBEEF, RespErr=0, RespValid rises 2 cycles after each accept.
REQ-033 sb 0x80 @0x013 over word 0x00000000, then lb @0x013 -> 0xFFFFFF80; lbu @0x013 -> 0x00000080; lw @0x010 -> 0x80000000.
REQ-034 lh @0x011 -> RespErr=1, RespRData=0; sw @0x012 with data 0x12345678 -> RespErr=1, memory unchanged.
REQ-035 Hold RespReady=0 for 5 cycles in RESP -> RespValid and RespRData stable, ReqReady=0; ReqValid pulses meanwhile are ignored.
REQ-036 Assert RST one cycle after accepting sw 0x11223344 @0x020 -> all outputs at reset values immediately; subsequent lw @0x020 returns the prior contents.
REQ-037 LATENCY=1 and LATENCY=15 builds, back-to-back lw with RespReady tied 1 -> one transaction per LATENCY+2 cycles.
